// File: rtl/mem_partial_access_ctrl.sv
// Load/store sequencer between the CPU and a word-wide synchronous data memory.
// Byte/half stores are read-modify-write: new data replaces the low bits, upper bits are kept.
module mem_partial_access_ctrl #(
    parameter int unsigned MEM_LATENCY = 1  // 1..4 cycles from read enable to valid mem_rdata
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] SIZE_ILLEGAL = 2'b00;
    localparam logic [1:0] SIZE_BYTE    = 2'b01;
    localparam logic [1:0] SIZE_HALF    = 2'b10;
    localparam logic [1:0] SIZE_WORD    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        cap_write;
    logic        cap_signed;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] rbuf;
    logic [2:0]  wait_cnt;

    // Byte offset is irrelevant: every access is a full aligned word.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, req_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_write  <= 1'b0;
            cap_signed <= 1'b0;
            cap_size   <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            rbuf       <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_write  <= req_write;
                        cap_signed <= req_signed;
                        cap_size   <= req_size;
                        cap_addr   <= {req_addr[31:2], 2'b00};
                        cap_wdata  <= req_wdata;
                    end
                end
                READ: begin
                    wait_cnt <= 3'(MEM_LATENCY);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        rbuf <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_size == SIZE_ILLEGAL) begin
                        state_nxt = RESP;
                    end else if (req_write && (req_size == SIZE_WORD)) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ:  state_nxt = WAIT;
            WAIT: begin
                if (wait_cnt == 3'd1) begin
                    state_nxt = cap_write ? WRITE : RESP;
                end
            end
            WRITE: state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                // Reset is asynchronous; IDLE alone must not advertise readiness while it is held.
                req_ready = ~reset;
            end
            READ: begin
                mem_en   = 1'b1;
                mem_addr = cap_addr;
            end
            WRITE: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = cap_addr;
                case (cap_size)
                    SIZE_BYTE: mem_wdata = {rbuf[31:8], cap_wdata[7:0]};
                    SIZE_HALF: mem_wdata = {rbuf[31:16], cap_wdata[15:0]};
                    default:   mem_wdata = cap_wdata;
                endcase
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = (cap_size == SIZE_ILLEGAL);
                if (!cap_write) begin
                    case (cap_size)
                        SIZE_BYTE: resp_rdata = {{24{cap_signed & rbuf[7]}}, rbuf[7:0]};
                        SIZE_HALF: resp_rdata = {{16{cap_signed & rbuf[15]}}, rbuf[15:0]};
                        SIZE_WORD: resp_rdata = rbuf;
                        default:   resp_rdata = '0;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_partial_access_ctrl.md
Name: mem_partial_access_ctrl

Overview:
- Multi-cycle sequencer between the CPU load/store stage and a word-wide synchronous data memory.
- Executes byte, half and word loads and stores.
- Partial stores are done as read-modify-write using the team's low-bits merge rule: the new data replaces bits [7:0] or [15:0] of the old word, and the upper bits are kept.
- One transaction is in flight at a time. The CPU stalls on req_ready.

Parameters:
MEM_LATENCY, 1, cycles from a read-enable cycle until mem_rdata is valid (legal range 1-4)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  CPU presents a request
req_ready  output  1  controller accepts a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  01 byte, 10 half, 11 word, 00 illegal
req_signed  input  1  loads: 1 sign-extend, 0 zero-extend
req_addr  input  32  byte address; bits [1:0] ignored
req_wdata  input  32  store data; low byte/half used for partial stores
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores, errors and when not valid
resp_err  output  1  illegal size; qualified by resp_valid
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_wdata  output  32  write data
mem_rdata  input  32  read data, valid MEM_LATENCY cycles after a read-enable cycle

Behaviour:
- Reset (asynchronous, any state): go to IDLE. All outputs are 0, including req_ready while reset is high. Reset mid-transaction aborts it, and no resp_valid is produced for it.
- States: IDLE, READ, WAIT, WRITE, RESP.
- Outputs are decoded from the current state and the captured request registers (Moore). The capture register and the read buffer are cleared by reset.
- IDLE: req_ready=1. On req_valid, capture write/size/signed/addr/wdata at the clock edge. Next state:
  - size 00 -> RESP with error
  - store word -> WRITE
  - otherwise -> READ
- READ: 1 cycle; mem_en=1, mem_we=0, mem_addr=captured word address; go to WAIT with the wait counter loaded with MEM_LATENCY.
- WAIT: MEM_LATENCY cycles; mem_en=0. On the last WAIT cycle, latch mem_rdata into the read buffer. Then go to WRITE for a store, or RESP for a load.
- WRITE: 1 cycle; mem_en=1, mem_we=1, mem_addr=captured word address. mem_wdata is:
  - word: wdata
  - half: {buf[31:16], wdata[15:0]}
  - byte: {buf[31:8], wdata[7:0]}
  - Next state RESP.
- RESP: 1 cycle; resp_valid=1, resp_err=1 only for size 00. Next state IDLE.
- Load result, from buffer buf:
  - byte: buf[7:0], extended to 32 bits by req_signed
  - half: buf[15:0], extended to 32 bits by req_signed
  - word: buf unchanged
- Latency (accept edge = cycle 0; L = MEM_LATENCY):
  - illegal: RESP in cycle 1
  - word store: WRITE c1, RESP c2
  - load: READ c1, WAIT c2..c1+L, RESP c2+L
  - partial store: WRITE c2+L, RESP c3+L
- req_ready=0 outside IDLE. req_valid is ignored there; the CPU holds its request.
- Back-to-back: a new request may be accepted in the IDLE cycle that immediately follows RESP. There is no bypass from RESP to the next request.
- mem_wdata=0 whenever mem_we=0. mem_addr=0 whenever mem_en=0.
- A read is always a full word. There is no lane strobe; merging is done only in the controller.

Test Plan:
- Word store, L=1: addr 0x10, wdata 0xCAFEBABE -> mem_en/mem_we high in c1 with mem_addr 0x10; resp_valid in c2, resp_err=0; memory word 0x10 = 0xCAFEBABE.
- Byte and half stores, L=1, mem[0x10]=0x12345678, wdata 0xCAFEBABE:
  - sb -> read c1, write c3 with 0x123456BE, resp c4.
  - sh on a fresh 0x12345678 -> write 0x1234BABE.
- Loads, L=1, mem[0x20]=0x8000ABF0:
  - lb signed -> resp_rdata 0xFFFFFFF0 in c3
  - lb unsigned -> 0x000000F0
  - lh signed -> 0xFFFFABF0
  - lw -> 0x8000ABF0
  - req_addr 0x23 behaves identically to 0x20.
- MEM_LATENCY=3: sh to a word holding 0x12345678 -> WAIT spans c2-c4, rdata latched at end of c4, write in c5, resp c6. Verify no extra mem_en cycles.
- Illegal size 00 with req_write=1 -> no mem_en at any point; resp_valid=1 and resp_err=1 in c1; resp_rdata=0.
- Reset asserted during WAIT of a partial store -> outputs 0 immediately, no write and no resp. After release, req_ready=1, and a fresh lw completes normally.
